// File: rtl/barrier_pkg.sv
// Shared definitions for the barrier synchronizer: FSM state encoding,
// default quiet/timeout intervals and a counter-width sanity helper.
// Imported by barrier_ctrl; quiet_counter is self-contained.
package barrier_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_QUIET = 2'd1,
    PROCEED    = 2'd2
  } state_e;

  localparam int QUIET_CYCLES_DEF   = 16;
  localparam int TIMEOUT_CYCLES_DEF = 50000;

  // True when a counter of 'width' bits can represent 'value'.
  function automatic bit fits_in(input int width, input int value);
    return (width >= 31) || (value < (1 << width));
  endfunction

endpackage

// File: rtl/quiet_counter.sv
// Saturating up-counter with synchronous clear and count enable.
// tc_o is high whenever the count sits at the terminal value TC; the count
// then holds there (never wraps) until cleared. Clear wins over enable.
module quiet_counter #(
  parameter int W  = 16,
  parameter int TC = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [W-1:0] TC_V = W'(TC);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear, else increment until the terminal value is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != TC_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_V);

endmodule

// File: rtl/barrier_ctrl.sv
// Barrier synchronizer: releases all agents once every net interface and the
// host request the barrier and all traffic has been quiet for QUIET_CYCLES.
// Optional feature macro BARRIER_TIMEOUT_EN adds a sticky timeout flag.
module barrier_ctrl
  import barrier_pkg::*;
#(
  parameter int NUM_IF         = 4,
  parameter int QUIET_CYCLES   = QUIET_CYCLES_DEF,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IF-1:0] if_activity,
  input  logic              pci_activity,
  input  logic [NUM_IF-1:0] if_good,
  input  logic              pci_good,
  output logic              barrier_proceed,
  output logic              barrier_waiting,
  output logic              barrier_timeout
);

  // Reject configurations the counters cannot represent.
  if ((QUIET_CYCLES < 1) || (TIMEOUT_CYCLES < 1) ||
      !fits_in(CNT_W, QUIET_CYCLES) || !fits_in(CNT_W, TIMEOUT_CYCLES)) begin : g_bad_cfg
    $error("barrier_ctrl: QUIET_CYCLES/TIMEOUT_CYCLES must be >= 1 and fit in CNT_W bits");
  end

  state_e state_q;
  state_e state_d;

  logic all_good;
  logic any_req;
  logic any_act;
  logic in_wait;
  logic quiet_tc;

  assign all_good = (&if_good) & pci_good;
  assign any_req  = (|if_good) | pci_good;
  assign any_act  = (|if_activity) | pci_activity;
  assign in_wait  = (state_q == WAIT_QUIET);

  // The quiet counter only runs in WAIT_QUIET; any activity restarts it and it
  // sits at zero in every other state so each entry starts a fresh interval.
  quiet_counter #(
    .W  (CNT_W),
    .TC (QUIET_CYCLES - 1)
  ) u_quiet (
    .clk   (clk),
    .reset (reset),
    .clr_i (!in_wait || any_act),
    .en_i  (in_wait && !any_act),
    .tc_o  (quiet_tc)
  );

  // Next state and decoded outputs; request withdrawal beats quiet detection,
  // and PROCEED is held until every request is gone so one barrier fires once.
  always_comb begin
    state_d         = state_q;
    barrier_proceed = 1'b0;
    barrier_waiting = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (all_good) begin
          state_d = WAIT_QUIET;
        end
      end
      WAIT_QUIET: begin
        barrier_waiting = 1'b1;
        if (!all_good) begin
          state_d = IDLE;
        end else if (!any_act && quiet_tc) begin
          state_d = PROCEED;
        end
      end
      PROCEED: begin
        barrier_proceed = 1'b1;
        if (!any_req) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts any barrier in progress immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef BARRIER_TIMEOUT_EN
  logic timeout_tc;
  logic timeout_q;
  logic timeout_d;

  // Counts cycles spent in WAIT_QUIET; cleared outside it, so both entry and
  // exit restart the interval. Terminal value is reached after TIMEOUT_CYCLES.
  quiet_counter #(
    .W  (CNT_W),
    .TC (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clr_i (!in_wait),
    .en_i  (in_wait),
    .tc_o  (timeout_tc)
  );

  // Sticky flag: set once the wait has lasted TIMEOUT_CYCLES, never forces release.
  always_comb begin
    timeout_d = timeout_q | (in_wait & timeout_tc);
  end

  // Timeout flag register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign barrier_timeout = timeout_q;
`else
  assign barrier_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_barrier_ctrl.sv
// Self-checking bench for barrier_ctrl: a cycle model pushes expected outputs
// into a scoreboard queue as stimulus is driven; each is popped and compared
// once the clock edge has produced the DUT output.
module tb_barrier_ctrl;

  localparam int NIF = 4;
  localparam int QC  = 16;
  localparam int TC  = 100;

  localparam int S_IDLE = 0;
  localparam int S_WAIT = 1;
  localparam int S_PROC = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NIF-1:0] if_activity = '0;
  logic           pci_activity = 1'b0;
  logic [NIF-1:0] if_good = '0;
  logic           pci_good = 1'b0;
  logic           barrier_proceed;
  logic           barrier_waiting;
  logic           barrier_timeout;

  barrier_ctrl #(
    .NUM_IF         (NIF),
    .QUIET_CYCLES   (QC),
    .CNT_W          (16),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .if_activity     (if_activity),
    .pci_activity    (pci_activity),
    .if_good         (if_good),
    .pci_good        (pci_good),
    .barrier_proceed (barrier_proceed),
    .barrier_waiting (barrier_waiting),
    .barrier_timeout (barrier_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic proceed;
    logic waiting;
    logic timeout;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model of the barrier behaviour.
  int   m_st    = S_IDLE;
  int   m_quiet = 0;
  bit   m_tof   = 1'b0;
`ifdef BARRIER_TIMEOUT_EN
  int   m_to    = 0;
`endif

  task automatic model_reset();
    m_st    = S_IDLE;
    m_quiet = 0;
    m_tof   = 1'b0;
`ifdef BARRIER_TIMEOUT_EN
    m_to    = 0;
`endif
    sb_q.delete();
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit ag;
    bit aa;
    bit ar;
    ag = (&if_good) & pci_good;
    aa = (|if_activity) | pci_activity;
    ar = (|if_good) | pci_good;
    case (m_st)
      S_IDLE: begin
        m_quiet = 0;
`ifdef BARRIER_TIMEOUT_EN
        m_to = 0;
`endif
        if (ag) m_st = S_WAIT;
      end
      S_WAIT: begin
`ifdef BARRIER_TIMEOUT_EN
        if (m_to == TC - 1) m_tof = 1'b1;
        else m_to++;
`endif
        if (!ag) m_st = S_IDLE;
        else if (aa) m_quiet = 0;
        else if (m_quiet == QC - 1) m_st = S_PROC;
        else m_quiet++;
      end
      default: begin
        m_quiet = 0;
`ifdef BARRIER_TIMEOUT_EN
        m_to = 0;
`endif
        if (!ar) m_st = S_IDLE;
      end
    endcase
  endtask

  // One clock: predict, push, clock, then pop and compare.
  task automatic step(input string tag);
    exp_t e;
    exp_t got;
    model_step();
    e.proceed = (m_st == S_PROC);
    e.waiting = (m_st == S_WAIT);
    e.timeout = m_tof;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    got = {barrier_proceed, barrier_waiting, barrier_timeout};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s cycle %0d: scoreboard empty", tag, cyc);
    end else begin
      e = sb_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL %s cycle %0d: proceed/waiting/timeout got %b required %b", tag, cyc, got, e);
      end
    end
  endtask

  // Step until barrier_proceed is seen, at most maxc cycles; -1 if never.
  task automatic run_until_proceed(input string tag, input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      step(tag);
      if (barrier_proceed === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Assert reset between clock edges; outputs must clear without an edge.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    checks++;
    if ({barrier_proceed, barrier_waiting, barrier_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL %s: outputs got %b required 000",
               tag, {barrier_proceed, barrier_waiting, barrier_timeout});
    end
    model_reset();
    if_activity  = '0;
    pci_activity = 1'b0;
    if_good      = '0;
    pci_good     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    do_reset("reset_state");
    for (int i = 0; i < 3; i++) step("reset_idle");
  endtask

  task automatic test_basic();
    int lat;
    do_reset("basic_rst");
    if_good  = '1;
    pci_good = 1'b1;
    step("basic");
    checks++;
    if (barrier_waiting !== 1'b1) begin
      errors++;
      $display("FAIL basic_waiting_c1: got %b required 1", barrier_waiting);
    end
    run_until_proceed("basic", 40, lat);
    checks++;
    if (lat + 1 != QC + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d required %0d", lat + 1, QC + 1);
    end
    for (int i = 0; i < 10; i++) step("basic_hold");
    if_good  = '0;
    pci_good = 1'b0;
    step("basic_drop");
    checks++;
    if (barrier_proceed !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop: proceed got %b required 0", barrier_proceed);
    end
  endtask

  task automatic test_activity_pulse();
    int first;
    first = -1;
    do_reset("pulse_rst");
    if_good  = '1;
    pci_good = 1'b1;
    for (int c = 1; c <= 40 && first < 0; c++) begin
      if_activity = (c == 10) ? 4'b0100 : 4'b0000;
      step("pulse");
      if (barrier_proceed === 1'b1) first = c;
    end
    if_activity = '0;
    checks++;
    if (first != 10 + QC) begin
      errors++;
      $display("FAIL pulse_latency: proceed cycle got %0d required %0d", first, 10 + QC);
    end
  endtask

  task automatic test_partial_request();
    int highs;
    int lat;
    highs = 0;
    do_reset("partial_rst");
    if_good  = 4'hE;
    pci_good = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step("partial_idle");
      if (barrier_proceed !== 1'b0 || barrier_waiting !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL partial_stays_idle: non-idle cycles got %0d required 0", highs);
    end
    if_good = 4'hF;
    run_until_proceed("partial_full", 40, lat);
    checks++;
    if (lat != QC + 1) begin
      errors++;
      $display("FAIL partial_release: latency got %0d required %0d", lat, QC + 1);
    end
  endtask

  task automatic test_partial_release();
    int lat;
    int drops;
    drops = 0;
    do_reset("prel_rst");
    if_good  = '1;
    pci_good = 1'b1;
    run_until_proceed("prel_setup", 40, lat);
    if_good = '0;
    for (int i = 0; i < 10; i++) begin
      step("prel_hold");
      if (barrier_proceed !== 1'b1) drops++;
    end
    checks++;
    if (drops != 0) begin
      errors++;
      $display("FAIL prel_hold: proceed-low cycles got %0d required 0", drops);
    end
    pci_good = 1'b0;
    step("prel_drop");
    checks++;
    if (barrier_proceed !== 1'b0) begin
      errors++;
      $display("FAIL prel_drop: proceed got %b required 0", barrier_proceed);
    end
    if_good  = '1;
    pci_good = 1'b1;
    run_until_proceed("prel_again", 40, lat);
    checks++;
    if (lat != QC + 1) begin
      errors++;
      $display("FAIL prel_again: latency got %0d required %0d", lat, QC + 1);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    do_reset("arst_rst");
    if_good  = '1;
    pci_good = 1'b1;
    for (int i = 0; i < 5; i++) step("arst_wait");
    do_reset("arst_in_wait");
    if_good  = '1;
    pci_good = 1'b1;
    run_until_proceed("arst_proc", 40, lat);
    checks++;
    if (barrier_proceed !== 1'b1) begin
      errors++;
      $display("FAIL arst_reach_proceed: proceed got %b required 1", barrier_proceed);
    end
    do_reset("arst_in_proceed");
    for (int i = 0; i < 3; i++) step("arst_after");
  endtask

`ifdef BARRIER_TIMEOUT_EN
  task automatic test_timeout();
    int first_to;
    int lat;
    first_to = -1;
    do_reset("to_rst");
    if_good      = '1;
    pci_good     = 1'b1;
    pci_activity = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      step("to_stuck");
      if (barrier_timeout === 1'b1 && first_to < 0) first_to = c;
    end
    checks++;
    if (first_to != TC + 1) begin
      errors++;
      $display("FAIL to_fire: timeout cycle got %0d required %0d", first_to, TC + 1);
    end
    pci_activity = 1'b0;
    run_until_proceed("to_release", 40, lat);
    checks++;
    if (lat != QC) begin
      errors++;
      $display("FAIL to_release: latency got %0d required %0d", lat, QC);
    end
    checks++;
    if (barrier_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: timeout got %b required 1", barrier_timeout);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_activity_pulse();
    test_partial_request();
    test_partial_release();
    test_async_reset();
`ifdef BARRIER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
